// File: rtl/bp_be_int_unbox_pipe.sv
// Multi-lane pipelined integer unbox: tagged register -> recoded operand at a requested tag.
// Latency stages_p cycles; elastic valid/ready with collapsing bubbles, synchronous flush.
module bp_be_int_unbox_pipe #(
  parameter int dword_width_p = 64,
  parameter int els_p         = 2,
  parameter int stages_p      = 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  flush_i,
  input  logic                                  v_i,
  output logic                                  ready_and_o,
  input  logic [els_p*(dword_width_p+2)-1:0]    reg_i,
  input  logic [els_p*2-1:0]                    tag_i,
  input  logic [els_p-1:0]                      unsigned_i,
  output logic                                  v_o,
  input  logic                                  ready_and_i,
  output logic [els_p*(dword_width_p+1)-1:0]    val_o,
  output logic [els_p-1:0]                      sigbox_o
);

  localparam int rw_lp = dword_width_p + 2;
  localparam int ow_lp = dword_width_p + 1;

  // Field width of a tag, capped at the datapath width (word == dword when 32-bit)
  function automatic int field_w(input logic [1:0] t);
    int w;
    case (t)
      2'd0:    w = 8;
      2'd1:    w = 16;
      2'd2:    w = 32;
      default: w = 64;
    endcase
    return (w > dword_width_p) ? dword_width_p : w;
  endfunction

  // Returns {sigbox, recoded value} for one lane
  function automatic logic [dword_width_p+1:0] unbox_lane(
    input logic [rw_lp-1:0] r,
    input logic [1:0]       t,
    input logic             u
  );
    logic [dword_width_p-1:0] v;
    logic [dword_width_p-1:0] raw;
    logic [dword_width_p:0]   o;
    logic [1:0]               rt;
    logic                     sb;
    logic                     msb_t;
    logic                     fill;
    int                       wr;
    int                       wt;
    rt = r[rw_lp-1 -: 2];
    v  = r[dword_width_p-1:0];
    wr = field_w(rt);
    wt = field_w(t);
    for (int i = 0; i < dword_width_p; i++)
      raw[i] = (i < wr) ? v[i] : v[dword_width_p-1];
    sb = (t >= rt);
    case (t)
      2'd0:    msb_t = raw[7];
      2'd1:    msb_t = raw[15];
      2'd2:    msb_t = raw[31];
      default: msb_t = raw[dword_width_p-1];
    endcase
    // Narrowing a signed value keeps the register's sign rather than the field's
    if (u)       fill = 1'b0;
    else if (sb) fill = msb_t;
    else         fill = raw[dword_width_p-1];
    for (int i = 0; i < dword_width_p; i++)
      o[i] = (i < wt) ? raw[i] : fill;
    o[dword_width_p] = fill;
    return {sb, o};
  endfunction

  function automatic logic stage_open(input logic [stages_p-1:0] vq, input int k);
    logic open;
    open = 1'b0;
    for (int j = 0; j < stages_p; j++)
      if (j >= k && !vq[j]) open = 1'b1;
    return open;
  endfunction

  logic [els_p*ow_lp-1:0]                 unbox_val;
  logic [els_p-1:0]                       unbox_sig;
  logic [stages_p-1:0]                    valid_q;
  logic [stages_p-1:0]                    adv;
  logic [stages_p-1:0][els_p*ow_lp-1:0]   val_q;
  logic [stages_p-1:0][els_p-1:0]         sig_q;

  always_comb begin
    logic [dword_width_p+1:0] res;
    unbox_val = '0;
    unbox_sig = '0;
    res       = '0;
    for (int l = 0; l < els_p; l++) begin
      res = unbox_lane(reg_i[l*rw_lp +: rw_lp], tag_i[l*2 +: 2], unsigned_i[l]);
      unbox_val[l*ow_lp +: ow_lp] = res[dword_width_p:0];
      unbox_sig[l]                = res[dword_width_p+1];
    end
  end

  // A stage can load if it or any stage downstream of it has a hole, or the sink drains
  always_comb begin
    adv = '0;
    for (int k = 0; k < stages_p; k++)
      adv[k] = ready_and_i | stage_open(valid_q, k);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      val_q   <= '0;
      sig_q   <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= v_i;
        if (v_i) begin
          val_q[0] <= unbox_val;
          sig_q[0] <= unbox_sig;
        end
      end
      for (int k = 1; k < stages_p; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            val_q[k] <= val_q[k-1];
            sig_q[k] <= sig_q[k-1];
          end
        end
      end
    end
  end

  assign ready_and_o = adv[0];
  assign v_o         = valid_q[stages_p-1];
  assign val_o       = val_q[stages_p-1];
  assign sigbox_o    = sig_q[stages_p-1];

endmodule

// File: tb/tb_bp_be_int_unbox_pipe.sv
// Directed bench: one 1-stage and one 3-stage unit sharing data/flush/reset inputs.
module tb_bp_be_int_unbox_pipe;
  localparam int RW = 66;
  localparam int OW = 65;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flush;
  logic [2*RW-1:0]  reg_v;
  logic [3:0]       tag_v;
  logic [1:0]       uns_v;
  logic             va, rdy_o_a, vo_a, rdy_i_a;
  logic [2*OW-1:0]  val_a;
  logic [1:0]       sig_a;
  logic             vb, rdy_o_b, vo_b, rdy_i_b;
  logic [2*OW-1:0]  val_b;
  logic [1:0]       sig_b;

  int errs = 0;
  int checks = 0;

  bp_be_int_unbox_pipe #(.dword_width_p(64), .els_p(2), .stages_p(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .v_i(va), .ready_and_o(rdy_o_a),
    .reg_i(reg_v), .tag_i(tag_v), .unsigned_i(uns_v), .v_o(vo_a), .ready_and_i(rdy_i_a),
    .val_o(val_a), .sigbox_o(sig_a));

  bp_be_int_unbox_pipe #(.dword_width_p(64), .els_p(2), .stages_p(3)) dut_b (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .v_i(vb), .ready_and_o(rdy_o_b),
    .reg_i(reg_v), .tag_i(tag_v), .unsigned_i(uns_v), .v_o(vo_b), .ready_and_i(rdy_i_b),
    .val_o(val_b), .sigbox_o(sig_b));

  task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [1:0] rt, input logic [63:0] v,
                          input logic [1:0] t, input logic u);
    reg_v[l*RW +: RW] = {rt, v};
    tag_v[l*2 +: 2]   = t;
    uns_v[l]          = u;
  endtask

  // Mask-based reference: {sigbox, 65-bit value}
  function automatic logic [65:0] model(input logic [1:0] rt, input logic [63:0] v,
                                        input logic [1:0] t, input logic u);
    int wr, wt;
    logic [63:0] mr, raw;
    logic [64:0] mt, res;
    logic sb, fill;
    wr  = 8 << rt;
    wt  = 8 << t;
    mr  = (wr == 64) ? {64{1'b1}} : ((64'd1 << wr) - 64'd1);
    raw = v[63] ? (v | ~mr) : (v & mr);
    mt  = (65'd1 << wt) - 65'd1;
    sb  = (t >= rt);
    if (u)       fill = 1'b0;
    else if (sb) fill = |(raw & (64'd1 << (wt - 1)));
    else         fill = raw[63];
    res = ({1'b0, raw} & mt) | (fill ? ~mt : 65'd0);
    return {sb, res};
  endfunction

  // Expected {sig[1:0], val[129:0]} for the inputs currently driven
  function automatic logic [131:0] exp_now();
    logic [131:0] r;
    logic [65:0]  m;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      m = model(reg_v[l*RW+64 +: 2], reg_v[l*RW +: 64], tag_v[l*2 +: 2], uns_v[l]);
      r[l*OW +: OW] = m[64:0];
      r[130+l]      = m[65];
    end
    return r;
  endfunction

  task automatic drive_bundle(input int i);
    logic [1:0]  a, b;
    logic [63:0] v;
    a = i[1:0];
    b = i[2:1] ^ 2'b01;
    v = {8{8'(i * 37 + 5)}} ^ 64'hF0E1_D2C3_8495_A6B7;
    set_lane(0, a, v, b, i[0]);
    set_lane(1, b, ~v, a, ~i[0]);
  endtask

  // One bundle through the 1-stage unit; returns at the negedge where it is visible
  task automatic pulse_a();
    va = 1'b1;
    rdy_i_a = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    @(negedge clk);
  endtask

  logic [63:0]  pats [4] = '{64'hFEDC_BA98_F654_B2F0, 64'h0123_4567_89AB_CD80,
                             64'h8000_0000_0000_7F7F, 64'h7FFF_8000_FF00_0180};
  logic [129:0] exp_v [8];
  logic [1:0]   exp_s [8];
  logic [3:0]   rp = 4'b1001;

  initial begin
    logic [131:0] e;
    logic [129:0] held_v;
    logic [1:0]   held_s;
    logic         stall;
    int sent, got, cnt;

    reset = 1'b1; flush = 1'b0; va = 1'b0; vb = 1'b0; rdy_i_a = 1'b0; rdy_i_b = 1'b0;
    reg_v = '0; tag_v = '0; uns_v = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_vo_a", vo_a, 1'b0);
    chk("rst_val_a", val_a, '0);
    chk("rst_sig_a", sig_a, 2'b00);
    chk("rst_rdy_a", rdy_o_a, 1'b1);
    chk("rst_vo_b", vo_b, 1'b0);
    chk("rst_val_b", val_b, '0);
    chk("rst_sig_b", sig_b, 2'b00);
    chk("rst_rdy_b", rdy_o_b, 1'b1);

    // Hand-computed vectors
    set_lane(0, 2'd2, 64'hFFFF_FFFF_8000_0000, 2'd0, 1'b0);
    set_lane(1, 2'd0, 64'h0000_0000_0000_0080, 2'd3, 1'b0);
    pulse_a();
    chk("t1_vo", vo_a, 1'b1);
    chk("t1_l0", val_a[0 +: OW], 65'h1_FFFF_FFFF_FFFF_FF00);
    chk("t1_l1", val_a[OW +: OW], 65'h0_0000_0000_0000_0080);
    chk("t1_sig", sig_a, 2'b10);

    set_lane(0, 2'd0, 64'hFFFF_FFFF_FFFF_FF80, 2'd2, 1'b0);
    set_lane(1, 2'd0, 64'hFFFF_FFFF_FFFF_FF80, 2'd2, 1'b1);
    pulse_a();
    chk("t3_signed", val_a[0 +: OW], 65'h1_FFFF_FFFF_FFFF_FF80);
    chk("t3_unsigned", val_a[OW +: OW], 65'h0_0000_0000_FFFF_FF80);
    chk("t3_sig", sig_a, 2'b11);

    // All register/requested tag pairs, lane0 signed, lane1 unsigned
    for (int rt = 0; rt < 4; rt++) begin
      for (int t = 0; t < 4; t++) begin
        set_lane(0, 2'(rt), pats[(rt + t) % 4], 2'(t), 1'b0);
        set_lane(1, 2'(rt), pats[(rt + 2 * t + 1) % 4], 2'(t), 1'b1);
        e = exp_now();
        pulse_a();
        chk($sformatf("sweep_val_%0d_%0d", rt, t), val_a, e[129:0]);
        chk($sformatf("sweep_sig_%0d_%0d", rt, t), sig_a, e[131:130]);
      end
    end

    for (int i = 0; i < 8; i++) begin
      drive_bundle(i);
      e = exp_now();
      exp_v[i] = e[129:0];
      exp_s[i] = e[131:130];
    end

    // 8-bundle stream into the 3-stage unit with ready toggling 1,0,0,1
    sent = 0; got = 0; cnt = 0; stall = 1'b0; held_v = '0; held_s = '0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(posedge clk); #1;
      rdy_i_b = rp[c % 4];
      if (sent < 8) begin
        drive_bundle(sent);
        vb = 1'b1;
      end else begin
        vb = 1'b0;
      end
      @(negedge clk);
      chk("stream_rdy_o", rdy_o_b, (cnt < 3) || rdy_i_b);
      if (stall) begin
        chk("stall_vo", vo_b, 1'b1);
        chk("stall_val", val_b, held_v);
        chk("stall_sig", sig_b, held_s);
      end
      if (vo_b && rdy_i_b) begin
        chk($sformatf("stream_val_%0d", got), val_b, exp_v[got]);
        chk($sformatf("stream_sig_%0d", got), sig_b, exp_s[got]);
        got++;
        cnt--;
      end
      stall  = vo_b && !rdy_i_b;
      held_v = val_b;
      held_s = sig_b;
      if (vb && rdy_o_b) begin
        sent++;
        cnt++;
      end
    end
    if (got != 8) chk("stream_count", 130'(got), 130'd8);
    @(posedge clk); #1;
    vb = 1'b0; rdy_i_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stream_no_dup", vo_b, 1'b0);
    end

    // Fill, then flush with a bundle presented
    @(posedge clk); #1;
    rdy_i_b = 1'b0;
    drive_bundle(0);
    vb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_bundle(1);
    flush = 1'b1;
    @(negedge clk);
    chk("full_rdy_o", rdy_o_b, 1'b0);
    chk("full_vo", vo_b, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; vb = 1'b0; rdy_i_b = 1'b1;
    @(negedge clk);
    chk("flush_vo", vo_b, 1'b0);
    chk("flush_rdy_o", rdy_o_b, 1'b1);
    drive_bundle(5);
    vb = 1'b1;
    @(posedge clk); #1;
    vb = 1'b0;
    @(negedge clk);
    chk("post_flush_lat1", vo_b, 1'b0);
    @(negedge clk);
    chk("post_flush_lat2", vo_b, 1'b0);
    @(negedge clk);
    chk("post_flush_lat3", vo_b, 1'b1);
    chk("post_flush_val", val_b, exp_v[5]);
    chk("post_flush_sig", sig_b, exp_s[5]);
    repeat (3) begin
      @(negedge clk);
      chk("flushed_gone", vo_b, 1'b0);
    end

    // Reset mid-stream, then reset together with flush
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      rdy_i_b = 1'b0;
      drive_bundle(2 + r);
      vb = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vb = 1'b0;
      reset = 1'b1;
      flush = (r == 1);
      @(posedge clk); #1;
      reset = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk($sformatf("mid_rst%0d_vo", r), vo_b, 1'b0);
      chk($sformatf("mid_rst%0d_val", r), val_b, '0);
      chk($sformatf("mid_rst%0d_sig", r), sig_b, 2'b00);
      chk($sformatf("mid_rst%0d_rdy", r), rdy_o_b, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bp_be_int_unbox_pipe.md
Name: bp_be_int_unbox_pipe

Overview:
Multi-lane, pipelined integer unbox unit for the calculator register-read path. Each lane converts a tagged integer register (dpath format: int tag plus raw value) into the recoded integer operand width at a requested tag and signedness. The unit adds an elastic valid/ready pipeline of configurable depth, a synchronous flush, and a per-lane sigbox indication that the single-lane combinational unbox does not provide.

Parameters:
dword_width_p, 64, raw value width per lane; legal values are 32 and 64.
els_p, 2, number of independent lanes sharing one handshake.
stages_p, 1, number of register stages; legal range 1..3; equals the latency.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
flush_i  in  1  synchronous pipeline flush
v_i  in  1  input bundle valid
ready_and_o  out  1  unit can accept a bundle this cycle
reg_i  in  els_p*(dword_width_p+2)  per lane {tag[1:0], val}
tag_i  in  els_p*2  per lane requested output tag
unsigned_i  in  els_p  per lane zero-extend request
v_o  out  1  output bundle valid
ready_and_i  in  1  consumer accepts the output bundle
val_o  out  els_p*(dword_width_p+1)  per lane recoded value
sigbox_o  out  els_p  per lane flag: requested tag >= register tag

Behaviour:
- Clock and reset: one clock (clk_i). Reset (reset_i) is synchronous and active-high.
- Tag encoding: byte=0, hword=1, word=2, dword=3. Field width W(t) = min(8<<t, dword_width_p). Let S = val[dword_width_p-1].
- Raw extraction from the register tag rt: raw = val[W(rt)-1:0], upper bits filled with S.
- Output encoding for requested tag t, with sigbox = (t >= rt):
  - unsigned_i=1: val_o = zero-extended raw[W(t)-1:0].
  - unsigned_i=0 and sigbox=1: sign-extend from raw[W(t)-1].
  - unsigned_i=0 and sigbox=0: extend with raw[dword_width_p-1].
  - All extensions fill to dword_width_p+1 bits.
- Lanes are independent. They share v_i, ready_and_o, v_o and ready_and_i.
- Computation is combinational ahead of stage 0. Stages 0..stages_p-1 each hold {valid, val[els_p], sigbox[els_p]}.
- Handshake:
  - Input is accepted when v_i & ready_and_o.
  - Output transfers when v_o & ready_and_i.
  - Stage k loads when stage k is empty or stage k+1 can accept. The last stage frees on ready_and_i.
  - ready_and_o = ~valid[0] | (stage 0 advances this cycle). It may depend combinationally on ready_and_i.
  - Bubbles collapse: with ready_and_i held high, throughput is one bundle per cycle and latency is exactly stages_p cycles.
- Outputs: v_o = valid[stages_p-1]. val_o and sigbox_o come from the last stage.
  - Data must hold stable while v_o=1 & ready_and_i=0.
  - Data is don't-care while v_o=0.
- Reset: all valid bits clear, all data registers clear. After reset: v_o=0, val_o=0, sigbox_o=0, ready_and_o=1.
- flush_i: clears all valid bits at the clock edge. A bundle presented in the same cycle is dropped. ready_and_o may be 1 during the flush, but the accept has no effect. flush_i has priority over load and advance. Data registers need not clear.
- Reset has priority over flush_i. Reset asserted mid-stream drops all in-flight bundles.
- Full pipeline with ready_and_i=0: ready_and_o=0, no state change.
- Full pipeline with ready_and_i=1 and v_i=1: simultaneous drain and accept, no bubble.
- dword_width_p=32: word and dword map to the same 32-bit field.

Test Plan:
- Defaults, lane0: rt=word, val=0xFFFF_FFFF_8000_0000, t=byte, signed -> sigbox=0, val_o=0x1_FFFF_FFFF_FFFF_FF00 one cycle after accept.
- Lane1: rt=byte, val=0x0000_0000_0000_0080, t=dword, signed -> sigbox=1, val_o=0x0_0000_0000_0000_0080.
- rt=byte, val=0xFFFF_FFFF_FFFF_FF80, t=word -> signed: 0x1_FFFF_FFFF_FFFF_FF80; unsigned: 0x0_0000_0000_FFFF_FF80. Sweep all 4x4 tag pairs against a behavioural model.
- stages_p=3, 8-bundle stream, ready_and_i toggling 1,0,0,1,... -> bundles emerge in order with no loss or duplication. Data holds under stall. ready_and_o=0 only when all 3 stages are full and ready_and_i=0.
- Pipeline full, assert flush_i with v_i=1 -> next cycle v_o=0. The flushed and presented bundles never appear. The following accept emerges after stages_p cycles.
- reset_i asserted with 2 bundles in flight -> next cycle v_o=0, val_o=0, sigbox_o=0, ready_and_o=1. Reset plus flush together behaves as reset.
